uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 100 ++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with RTS/CTS handshake, optional parity and 1/2 stop bits.
module uart_tx #(
  parameter int DIV_W = 16
) (
  input  logic             tck,
  input  logic             rst_n,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop2_i,
  output logic             tx_rts_n_o,
  input  logic             tx_cts_n_i,
  input  logic             tx_enable_i,
  output logic             tx_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {IDLE, REQ, START, DATA, PARITY, STOP} state_t;

  state_t           state, next_state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       shreg;
  logic [2:0]       idx;
  logic             stop_cnt;
  logic             par_en_q;
  logic             par_bit_q;
  logic             stop2_q;
  logic             bit_done;

  assign bit_done = (cnt == div_q);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (data_valid_i) next_state = REQ;
      REQ:     if (!tx_cts_n_i && tx_enable_i) next_state = START;
      START:   if (bit_done) next_state = DATA;
      DATA:    if (bit_done && idx == 3'd7) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (bit_done && stop_cnt == stop2_q) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    data_ready_o = (state == IDLE);
    tx_rts_n_o   = (state == IDLE);
    busy_o       = (state != IDLE);
    tx_o         = 1'b1;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shreg[0];
      PARITY:  tx_o = par_bit_q;
      default: tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div_q     <= '0;
      shreg     <= '0;
      idx       <= '0;
      stop_cnt  <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state <= next_state;

      // Frame configuration is frozen at accept so later input changes cannot disturb it.
      if (state == IDLE && data_valid_i) begin
        shreg     <= data_i;
        div_q     <= baud_div_i;
        par_en_q  <= parity_en_i;
        par_bit_q <= (^data_i) ^ parity_odd_i;
        stop2_q   <= stop2_i;
      end

      if (next_state != state || bit_done) cnt <= '0;
      else                                 cnt <= cnt + DIV_W'(1);

      if (next_state == START) begin
        idx <= 3'd0;
      end else if (state == DATA && bit_done) begin
        idx   <= idx + 3'd1;
        shreg <= {1'b0, shreg[7:1]};
      end

      if (state != STOP)  stop_cnt <= 1'b0;
      else if (bit_done)  stop_cnt <= ~stop_cnt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: directed frames checked by a serial-line monitor.
module tb_uart_tx;

  logic        tck = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [15:0] baud_div_i = '0;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        stop2_i = 1'b0;
  logic        tx_rts_n_o;
  logic        tx_cts_n_i = 1'b0;
  logic        tx_enable_i = 1'b1;
  logic        tx_o;
  logic        busy_o;

  uart_tx #(.DIV_W(16)) dut (
    .tck(tck), .rst_n(rst_n), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o), .baud_div_i(baud_div_i), .parity_en_i(parity_en_i),
    .parity_odd_i(parity_odd_i), .stop2_i(stop2_i), .tx_rts_n_o(tx_rts_n_o),
    .tx_cts_n_i(tx_cts_n_i), .tx_enable_i(tx_enable_i), .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic [11:0] pat;   // line level per bit period, bit 0 = start bit
    int          n;     // bit periods in frame
    int          div;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  bit     mon_off = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a low line level outside reset starts a frame that must match the oldest expectation.
  initial begin
    frame_t e;
    int     bad_cyc;
    logic   exp_bit;
    forever begin
      @(negedge tck);
      if (rst_n && !mon_off && tx_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'(tx_o), 32'd1);
        end else begin
          e = exp_q.pop_front();
          bad_cyc = -1;
          for (int k = 0; k < e.n * (e.div + 1); k++) begin
            if (k > 0) @(negedge tck);
            exp_bit = e.pat[k / (e.div + 1)];
            if (bad_cyc < 0 && (tx_o !== exp_bit || busy_o !== 1'b1 || tx_rts_n_o !== 1'b0))
              bad_cyc = k;
          end
          chk("frame_bits_first_bad_cycle", 32'(bad_cyc), 32'hFFFF_FFFF);
          @(negedge tck);
          chk("frame_end_idle", {29'd0, data_ready_o, tx_rts_n_o, tx_o}, 32'b111);
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge tck);
    while (data_ready_o !== 1'b1 && t < 2000) begin
      @(negedge tck);
      t++;
    end
    if (data_ready_o !== 1'b1) chk("ready_timeout", 32'(data_ready_o), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] div, input logic pe,
                      input logic odd, input logic s2, input logic [11:0] pat,
                      input int n, input bit push);
    frame_t e;
    wait_ready();
    data_i = d; baud_div_i = div; parity_en_i = pe; parity_odd_i = odd; stop2_i = s2;
    data_valid_i = 1'b1;
    if (push) begin
      e.pat = pat; e.n = n; e.div = int'(div);
      exp_q.push_back(e);
    end
    @(posedge tck);
    #1;
    data_valid_i = 1'b0;
    data_i = ~d; baud_div_i = 16'h00FF; parity_en_i = ~pe; parity_odd_i = ~odd; stop2_i = ~s2;
  endtask

  task automatic wait_start();
    int t = 0;
    @(negedge tck);
    while (tx_o !== 1'b0 && t < 500) begin
      @(negedge tck);
      t++;
    end
    if (tx_o !== 1'b0) chk("start_timeout", 32'(tx_o), 32'd0);
  endtask

  initial begin
    frame_t e;
    bit     ok;
    int     t;

    #22;
    chk("reset_outputs", {28'd0, tx_o, tx_rts_n_o, data_ready_o, busy_o}, 32'b1110);
    @(negedge tck);
    rst_n = 1'b1;

    // 0x55, div 3, no parity, 1 stop
    send(8'h55, 16'd3, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 1'b1);
    // 0xA5, div 1, even then odd parity
    send(8'hA5, 16'd1, 1'b1, 1'b0, 1'b0, 12'h54A, 11, 1'b1);
    send(8'hA5, 16'd1, 1'b1, 1'b1, 1'b0, 12'h74A, 11, 1'b1);
    // 0xFF, div 0, two stop bits
    send(8'hFF, 16'd0, 1'b0, 1'b0, 1'b1, 12'h7FE, 11, 1'b1);

    // CTS held off: block must park in REQ
    wait_ready();
    tx_cts_n_i = 1'b1;
    send(8'h3C, 16'd2, 1'b0, 1'b0, 1'b0, 12'h278, 10, 1'b1);
    ok = 1'b1;
    repeat (50) begin
      @(negedge tck);
      if (tx_rts_n_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b1 || data_ready_o !== 1'b0) ok = 1'b0;
    end
    chk("req_wait_cts_high", 32'(ok), 32'd1);
    tx_cts_n_i = 1'b0;
    @(negedge tck);
    chk("start_after_cts", 32'(tx_o), 32'd0);

    // CTS/enable withdrawn mid-DATA: frame must still complete
    send(8'h96, 16'd2, 1'b1, 1'b1, 1'b0, 12'h72C, 11, 1'b1);
    wait_start();
    repeat (10) @(negedge tck);
    tx_cts_n_i = 1'b1;
    tx_enable_i = 1'b0;
    wait_ready();
    tx_cts_n_i = 1'b0;
    tx_enable_i = 1'b1;

    // data_valid held across two frames
    wait_ready();
    data_i = 8'h0F; baud_div_i = 16'd0; parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0;
    data_valid_i = 1'b1;
    e.pat = 12'h21E; e.n = 10; e.div = 0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(posedge tck);
    #1;
    wait_ready();
    @(posedge tck);
    #1;
    data_valid_i = 1'b0;

    // Reset during DATA bit 4
    wait_ready();
    repeat (15) @(negedge tck);
    mon_off = 1'b1;
    send(8'hA5, 16'd1, 1'b0, 1'b0, 1'b0, 12'h000, 0, 1'b0);
    wait_start();
    repeat (10) @(negedge tck);
    chk("pre_reset_bit4", 32'(tx_o), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_frame", {28'd0, tx_o, tx_rts_n_o, data_ready_o, busy_o}, 32'b1110);
    repeat (2) @(negedge tck);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (30) begin
      @(negedge tck);
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || data_ready_o !== 1'b1) ok = 1'b0;
    end
    chk("post_reset_quiet", 32'(ok), 32'd1);
    mon_off = 1'b0;

    // One more frame after reset proves the block recovers cleanly
    send(8'h55, 16'd0, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 1'b1);

    t = 0;
    @(negedge tck);
    while ((exp_q.size() != 0 || data_ready_o !== 1'b1) && t < 2000) begin
      @(negedge tck);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge tck);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
